// File: rtl/arrive_depart_ctrl_n_if.sv
// Switch, bay-state and request/counter bundle for arrive_depart_ctrl_n.
// The master drives switches, occupancy and ack; the slave returns requests and counts.
interface arrive_depart_ctrl_n_if #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CNT_W    = 8
);
    logic [CHANNELS-1:0] arrive_sw;
    logic [CHANNELS-1:0] depart_sw;
    logic [CHANNELS-1:0] occupied;
    logic [CHANNELS-1:0] ack;
    logic [CHANNELS-1:0] arrive_req;
    logic [CHANNELS-1:0] depart_req;
    logic [CHANNELS-1:0] reject;
    logic [CNT_W-1:0]    arrive_cnt;
    logic [CNT_W-1:0]    depart_cnt;

    modport master (
        output arrive_sw, depart_sw, occupied, ack,
        input  arrive_req, depart_req, reject, arrive_cnt, depart_cnt
    );

    modport slave (
        input  arrive_sw, depart_sw, occupied, ack,
        output arrive_req, depart_req, reject, arrive_cnt, depart_cnt
    );
endinterface

// File: rtl/arrive_depart_ctrl_n.sv
// Per-bay debounced arrive/depart request generator with saturating event totals.
// Define ARRIVE_DEPART_HOLD_EN to hold arrive_req/depart_req until ack instead of pulsing.
module arrive_depart_ctrl_n #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    arrive_depart_ctrl_n_if.slave  bus
);
    localparam int unsigned       STAB_W    = $clog2(DEBOUNCE);
    localparam int unsigned       SUM_W     = CNT_W + $clog2(CHANNELS + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(DEBOUNCE - 1);

    logic [CHANNELS-1:0][1:0]        s_q, s_d;
    logic [CHANNELS-1:0][1:0]        deb_q, deb_d;
    logic [CHANNELS-1:0][STAB_W-1:0] stab_q, stab_d;
    logic [CHANNELS-1:0]             chg_q, chg_d;
    logic [CHANNELS-1:0]             arr_req_q, arr_req_d;
    logic [CHANNELS-1:0]             dep_req_q, dep_req_d;
    logic [CHANNELS-1:0]             rej_q, rej_d;
    logic [CHANNELS-1:0]             arr_ev, dep_ev;
    logic [CNT_W-1:0]                arr_cnt_q, arr_cnt_d;
    logic [CNT_W-1:0]                dep_cnt_q, dep_cnt_d;
    logic [SUM_W-1:0]                arr_sum, dep_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q       <= '0;
            deb_q     <= '0;
            stab_q    <= '0;
            chg_q     <= '0;
            arr_req_q <= '0;
            dep_req_q <= '0;
            rej_q     <= '0;
            arr_cnt_q <= '0;
            dep_cnt_q <= '0;
        end else begin
            s_q       <= s_d;
            deb_q     <= deb_d;
            stab_q    <= stab_d;
            chg_q     <= chg_d;
            arr_req_q <= arr_req_d;
            dep_req_q <= dep_req_d;
            rej_q     <= rej_d;
            arr_cnt_q <= arr_cnt_d;
            dep_cnt_q <= dep_cnt_d;
        end
    end

    // Debounce, then classify the cycle after deb moves against the current bay state.
    always_comb begin
        s_d    = s_q;
        deb_d  = deb_q;
        stab_d = stab_q;
        chg_d  = '0;
        arr_ev = '0;
        dep_ev = '0;
        rej_d  = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            s_d[i] = {bus.arrive_sw[i], bus.depart_sw[i]};
            if (s_q[i] == deb_q[i] || s_d[i] != s_q[i]) begin
                stab_d[i] = '0;
            end else if (stab_q[i] == STAB_LAST) begin
                deb_d[i]  = s_q[i];
                stab_d[i] = '0;
                chg_d[i]  = 1'b1;
            end else begin
                stab_d[i] = stab_q[i] + STAB_W'(1);
            end

            if (chg_q[i]) begin
                case (deb_q[i])
                    2'b10: begin
                        if (bus.occupied[i]) rej_d[i]  = 1'b1;
                        else                 arr_ev[i] = 1'b1;
                    end
                    2'b01: begin
                        if (bus.occupied[i]) dep_ev[i] = 1'b1;
                        else                 rej_d[i]  = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Held requests: new event wins over ack, opposite event replaces the held one.
`ifdef ARRIVE_DEPART_HOLD_EN
    always_comb begin
        arr_req_d = arr_ev | (arr_req_q & ~bus.ack & ~dep_ev);
        dep_req_d = dep_ev | (dep_req_q & ~bus.ack & ~arr_ev);
    end
`else
    logic unused_ack;
    assign unused_ack = ^bus.ack;

    always_comb begin
        arr_req_d = arr_ev;
        dep_req_d = dep_ev;
    end
`endif

    // Saturating totals of accepted events across all channels.
    always_comb begin
        arr_sum = SUM_W'(arr_cnt_q);
        dep_sum = SUM_W'(dep_cnt_q);
        for (int i = 0; i < int'(CHANNELS); i++) begin
            arr_sum = arr_sum + SUM_W'(arr_ev[i]);
            dep_sum = dep_sum + SUM_W'(dep_ev[i]);
        end
        arr_cnt_d = (arr_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : arr_sum[CNT_W-1:0];
        dep_cnt_d = (dep_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : dep_sum[CNT_W-1:0];
    end

    assign bus.arrive_req = arr_req_q;
    assign bus.depart_req = dep_req_q;
    assign bus.reject     = rej_q;
    assign bus.arrive_cnt = arr_cnt_q;
    assign bus.depart_cnt = dep_cnt_q;
endmodule
